// File: rtl/cam_link_pkg.sv
// Shared framing constants and receive-state encoding for the 4-bit CAM nibble link.
// Both the transmitter and the deserializer use these constants.
package cam_link_pkg;

    localparam int CAM_NIBBLES_PER_PACKET = 10;
    localparam int CAM_SYNC_NIBBLE        = 8;
    localparam int CAM_DATA_NIBBLES       = 8;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } cam_rx_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-stage synchronizer for the {pclk, sync, data} bus, plus a PCLK rise strobe
// that lines up with the synchronized sync/data bits.
module cam_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 6
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-2:0] q_data,
    output logic             rise
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic                              pclk_prev;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= '0;
            pclk_prev <= 1'b0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            pclk_prev <= stage_q[SYNC_STAGES-1][WIDTH-1];
        end
    end

    // The MSB is PCLK; everything below it travels in the same stage so it is aligned with the rise.
    assign q_data = stage_q[SYNC_STAGES-1][WIDTH-2:0];
    assign rise   = stage_q[SYNC_STAGES-1][WIDTH-1] & ~pclk_prev;

endmodule

// File: rtl/cam_deserializer.sv
// Receive side of the CAM nibble link: rebuilds 32-bit words and flags framing errors.
// Define CAM_DESER_STATS_EN to build the saturating word/error counters.
//
// state | meaning
// HUNT  | searching for a sync nibble to find packet alignment
// DATA  | collecting data nibbles (count 0..7), then expecting the sync nibble (count 8)
// PAD   | discarding the pad nibble that follows sync
module cam_deserializer
    import cam_link_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int IDLE_TIMEOUT  = 16,
    parameter int TIMEOUT_WIDTH = 5
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cam_pclk,
    input  logic        cam_sync,
    input  logic [3:0]  cam_data,
    output logic        word_valid_o,
    output logic [31:0] word_data_o,
    output logic        frame_err_o,
    output logic [15:0] word_count_o,
    output logic [15:0] err_count_o
);

    localparam logic [TIMEOUT_WIDTH-1:0] IDLE_MAX = TIMEOUT_WIDTH'(IDLE_TIMEOUT);
    localparam logic [3:0]               LAST_CNT = 4'(CAM_DATA_NIBBLES);

    logic [4:0]               s_bus;
    logic                     s_rise;
    logic                     s_sync;
    logic [3:0]               s_nib;
    cam_rx_state_t            state;
    logic [3:0]               nib_cnt;
    logic [TIMEOUT_WIDTH-1:0] idle_cnt;
    logic [31:0]              shreg;

    cam_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (6)
    ) u_sync_edge (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .d      ({cam_pclk, cam_sync, cam_data}),
        .q_data (s_bus),
        .rise   (s_rise)
    );

    assign s_sync = s_bus[4];
    assign s_nib  = s_bus[3:0];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            nib_cnt      <= 4'd0;
            idle_cnt     <= '0;
            shreg        <= 32'd0;
            word_data_o  <= 32'd0;
            word_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            word_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;

            if (s_rise) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (s_rise) begin
                case (state)
                    HUNT: begin
                        if (s_sync) state <= PAD;
                    end
                    DATA: begin
                        if (nib_cnt < LAST_CNT) begin
                            if (s_sync) begin
                                frame_err_o <= 1'b1;
                                state       <= PAD;
                                nib_cnt     <= 4'd0;
                            end else begin
                                shreg   <= {s_nib, shreg[31:4]};
                                nib_cnt <= nib_cnt + 4'd1;
                            end
                        end else if (s_sync) begin
                            word_data_o  <= shreg;
                            word_valid_o <= 1'b1;
                            state        <= PAD;
                            nib_cnt      <= 4'd0;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= HUNT;
                            nib_cnt     <= 4'd0;
                        end
                    end
                    PAD: begin
                        state   <= DATA;
                        nib_cnt <= 4'd0;
                    end
                    default: begin
                        state   <= HUNT;
                        nib_cnt <= 4'd0;
                    end
                endcase
            end else if (idle_cnt == IDLE_MAX) begin
                // An idle link is a packet boundary; a partial word there is a framing error.
                if (state == DATA && nib_cnt != 4'd0) frame_err_o <= 1'b1;
                state   <= DATA;
                nib_cnt <= 4'd0;
            end
        end
    end

`ifdef CAM_DESER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            word_count_o <= 16'h0000;
            err_count_o  <= 16'h0000;
        end else begin
            if (word_valid_o && word_count_o != 16'hFFFF) word_count_o <= word_count_o + 16'd1;
            if (frame_err_o && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
        end
    end
`else
    assign word_count_o = 16'h0000;
    assign err_count_o  = 16'h0000;
`endif

endmodule
